// File: rtl/segment_decoder.sv
// Decodes a two-digit seven-segment pair (tens, units) back to a value 0-15.
// A capture starts on a ready rise, waits for a stable pattern, then holds the result until ack.
module segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       dse,
  input  logic [6:0]       dsd,
  input  logic             ready,
  input  logic             ack,
  output logic [3:0]       s,
  output logic             valid,
  output logic             err,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned    CntW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [6:0]     SegBlank   = 7'b0000000;
  localparam logic [6:0]     SegZero    = 7'b1111110;
  localparam logic [6:0]     SegOne     = 7'b0110000;

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e           state_q, state_d;
  logic             ready_q;
  logic [13:0]      snap_q, snap_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       s_q, s_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;
  logic             rise;
  logic             enter_hold;
  logic [4:0]       dec;

  // Returns {legal, digit} for a single units pattern.
  function automatic logic [4:0] seg_units(input logic [6:0] seg);
    case (seg)
      7'b1111110: return 5'b1_0000;
      7'b0110000: return 5'b1_0001;
      7'b1101101: return 5'b1_0010;
      7'b1111001: return 5'b1_0011;
      7'b0110011: return 5'b1_0100;
      7'b1011011: return 5'b1_0101;
      7'b1011111: return 5'b1_0110;
      7'b1110000: return 5'b1_0111;
      7'b1111111: return 5'b1_1000;
      7'b1110011: return 5'b1_1001;
      default:    return 5'b0_0000;
    endcase
  endfunction

  // Returns {err, value}; illegal pairs decode to value 0.
  function automatic logic [4:0] decode_pair(input logic [13:0] pair);
    logic [4:0] u;
    u = seg_units(pair[6:0]);
    if (pair[13:7] == SegBlank && u[4]) begin
      return {1'b0, u[3:0]};
    end else if (pair[13:7] == SegOne && u[4] && u[3:0] <= 4'd5) begin
      return {1'b0, u[3:0] + 4'd10};
    end else if (pair[13:7] == SegZero && pair[6:0] == SegOne) begin
      return {1'b0, 4'd10};
    end
    return 5'b1_0000;
  endfunction

  assign rise = ready & ~ready_q;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    valid_d    = valid_q;
    err_d      = err_q;
    ecnt_d     = ecnt_q;
    enter_hold = 1'b0;
    dec        = 5'b0_0000;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          snap_d = {dse, dsd};
          cnt_d  = CntOne;
          if (cnt_d == CntTarget) enter_hold = 1'b1;
          else                    state_d    = StSettle;
        end
      end
      StSettle: begin
        if (!ready) begin
          state_d = StIdle;
        end else begin
          if ({dse, dsd} == snap_q) begin
            cnt_d = cnt_q + CntOne;
          end else begin
            snap_d = {dse, dsd};
            cnt_d  = CntOne;
          end
          if (cnt_d == CntTarget) enter_hold = 1'b1;
        end
      end
      StHold: begin
        if (ack) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_hold) begin
      dec     = decode_pair(snap_d);
      state_d = StHold;
      s_d     = dec[3:0];
      err_d   = dec[4];
      valid_d = 1'b1;
      if (dec[4] && ecnt_q != {ERR_W{1'b1}}) ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      snap_q  <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= (state_d != StIdle);
      ecnt_q  <= ecnt_d;
    end
  end

  assign s         = s_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_segment_decoder.sv
// Self-checking bench for segment_decoder: vector table, corner sequences and random captures
// compared against a pattern-table reference model.
module tb_segment_decoder;

  localparam int unsigned SC      = 3;
  localparam int unsigned EW      = 4;
  localparam int unsigned ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    dse, dsd;
  logic          ready, ack;
  logic [3:0]    s;
  logic          valid, err, busy;
  logic [EW-1:0] err_count;

  segment_decoder #(.STABLE_CYCLES(SC), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .dse(dse), .dsd(dsd), .ready(ready), .ack(ack),
    .s(s), .valid(valid), .err(err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] te;
    logic [6:0] un;
    logic [3:0] es;
    logic       ee;
  } vec_t;

  logic [6:0] tab [10];
  vec_t       vecs [10];
  int         total  = 0;
  int         passes = 0;
  int         model_cnt = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: locate units digit in the pattern table, then apply the tens-digit rules.
  task automatic ref_decode(input logic [6:0] te, input logic [6:0] un,
                            output logic [3:0] es, output logic ee);
    int idx = -1;
    for (int i = 0; i < 10; i++) if (tab[i] == un) idx = i;
    es = 4'd0;
    ee = 1'b1;
    if (te == 7'd0 && idx >= 0) begin
      es = 4'(idx); ee = 1'b0;
    end else if (te == tab[1] && idx >= 0 && idx <= 5) begin
      es = 4'(10 + idx); ee = 1'b0;
    end else if (te == tab[0] && un == tab[1]) begin
      es = 4'd10; ee = 1'b0;
    end
  endtask

  task automatic note_err(input logic ee);
    if (ee && model_cnt < ERR_MAX) model_cnt++;
  endtask

  task automatic capture(input logic [6:0] te, input logic [6:0] un, input string tag);
    logic [3:0] es;
    logic       ee;
    ref_decode(te, un, es, ee);
    ready = 1'b0;
    step();
    dse = te; dsd = un; ready = 1'b1;
    repeat (SC - 1) step();
    check({tag, ".early_valid"}, valid, 0);
    step();
    note_err(ee);
    check({tag, ".valid"}, valid, 1);
    check({tag, ".s"}, s, es);
    check({tag, ".err"}, err, ee);
    check({tag, ".err_count"}, err_count, model_cnt);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, ".valid_after_ack"}, valid, 0);
    check({tag, ".s_after_ack"}, s, es);
    ready = 1'b0;
  endtask

  initial begin
    logic [6:0] te, un;
    int         pick;

    tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
    vecs[0] = '{7'b0000000, 7'b1111001, 4'd3,  1'b0};
    vecs[1] = '{7'b0110000, 7'b1011011, 4'd15, 1'b0};
    vecs[2] = '{7'b1111110, 7'b0110000, 4'd10, 1'b0};
    vecs[3] = '{7'b0110000, 7'b1111110, 4'd10, 1'b0};
    vecs[4] = '{7'b0110000, 7'b1011111, 4'd0,  1'b1};
    vecs[5] = '{7'b0000000, 7'b1111110, 4'd0,  1'b0};
    vecs[6] = '{7'b0000000, 7'b1110011, 4'd9,  1'b0};
    vecs[7] = '{7'b1111110, 7'b1111110, 4'd0,  1'b1};
    vecs[8] = '{7'b0000000, 7'b0000000, 4'd0,  1'b1};
    vecs[9] = '{7'b0110000, 7'b0110011, 4'd14, 1'b0};

    reset = 1'b1; dse = '0; dsd = '0; ready = 1'b0; ack = 1'b0;
    repeat (2) step();
    check("rst.s", s, 0);
    check("rst.valid", valid, 0);
    check("rst.err", err, 0);
    check("rst.busy", busy, 0);
    check("rst.err_count", err_count, 0);
    reset = 1'b0;
    step();

    // Table vectors: expected values written out by hand.
    for (int i = 0; i < 10; i++) begin
      ready = 1'b0;
      step();
      dse = vecs[i].te; dsd = vecs[i].un; ready = 1'b1;
      step();
      check("vec.busy", busy, 1);
      repeat (SC - 1) step();
      if (vecs[i].ee && model_cnt < ERR_MAX) model_cnt++;
      check("vec.valid", valid, 1);
      check("vec.s", s, vecs[i].es);
      check("vec.err", err, vecs[i].ee);
      check("vec.err_count", err_count, model_cnt);
      ack = 1'b1; step(); ack = 1'b0;
      check("vec.ack", valid, 0);
    end
    ready = 1'b0;

    // Value 3, ack at E5.
    step();
    dse = 7'd0; dsd = tab[3]; ready = 1'b1;
    step(); step();
    check("e5.valid_e1", valid, 0);
    step();
    check("e5.valid_e2", valid, 1);
    check("e5.s", s, 3);
    step(); step();
    check("e5.valid_e4", valid, 1);
    ack = 1'b1; step(); ack = 1'b0;
    check("e5.valid_after", valid, 0);
    check("e5.s_after", s, 3);
    check("e5.busy_after", busy, 0);
    ready = 1'b0;

    // Input change at E1 restarts the settle count.
    step();
    dse = 7'd0; dsd = tab[1]; ready = 1'b1;
    step();
    dsd = tab[2];
    step();
    check("chg.e1", valid, 0);
    step();
    check("chg.e2", valid, 0);
    step();
    check("chg.e3", valid, 1);
    check("chg.s", s, 2);
    ack = 1'b1; step(); ack = 1'b0; ready = 1'b0;

    // Ready dropped mid-settle on an illegal pattern: nothing captured or counted.
    step();
    dse = tab[1]; dsd = 7'b1011111; ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    check("drop.busy", busy, 0);
    repeat (4) step();
    check("drop.valid", valid, 0);
    check("drop.err_count", err_count, model_cnt);

    // Rise during HOLD ignored; no restart while ready stays high after ack.
    dse = 7'd0; dsd = tab[7]; ready = 1'b1;
    repeat (SC) step();
    check("hold.valid", valid, 1);
    check("hold.s", s, 7);
    dsd = tab[8]; ready = 1'b0;
    step();
    ready = 1'b1;
    repeat (3) step();
    check("hold.rise_ignored_valid", valid, 1);
    check("hold.rise_ignored_s", s, 7);
    ack = 1'b1; step(); ack = 1'b0;
    repeat (5) step();
    check("hold.no_restart_busy", busy, 0);
    check("hold.no_restart_valid", valid, 0);
    ready = 1'b0;
    step();
    ready = 1'b1;
    repeat (SC) step();
    check("hold.retrigger_valid", valid, 1);
    check("hold.retrigger_s", s, 8);
    ack = 1'b1; step(); ack = 1'b0; ready = 1'b0;

    // Random captures against the reference model.
    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 3));
      if (pick == 0) begin
        te = 7'd0; un = tab[$urandom_range(0, 9)];
      end else if (pick == 1) begin
        te = tab[1]; un = tab[$urandom_range(0, 9)];
      end else if (pick == 2) begin
        te = tab[$urandom_range(0, 1)]; un = tab[$urandom_range(0, 9)];
        un[$urandom_range(0, 6)] ^= ($urandom_range(0, 1) == 1);
      end else begin
        te = 7'($urandom); un = 7'($urandom);
      end
      capture(te, un, "rnd");
    end

    // Saturation of the error counter.
    for (int n = 0; n < 20; n++) capture(tab[1], tab[6], "sat");
    check("sat.final", err_count, ERR_MAX);

    // Async reset during SETTLE.
    step();
    dse = 7'd0; dsd = tab[4]; ready = 1'b1;
    step();
    check("arst_settle.busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_settle.busy", busy, 0);
    check("arst_settle.err_count", err_count, 0);
    model_cnt = 0;
    step();
    ready = 1'b0;
    reset = 1'b0;
    step();

    // Async reset during HOLD with an error result present.
    dse = tab[1]; dsd = tab[9]; ready = 1'b1;
    repeat (SC) step();
    check("arst_hold.valid_pre", valid, 1);
    check("arst_hold.err_pre", err, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_hold.valid", valid, 0);
    check("arst_hold.err", err, 0);
    check("arst_hold.s", s, 0);
    check("arst_hold.busy", busy, 0);
    check("arst_hold.err_count", err_count, 0);
    model_cnt = 0;

    // Ready held through reset counts as a rise after release.
    step(); step();
    reset = 1'b0;
    dse = 7'd0; dsd = tab[5];
    step();
    check("rel.busy", busy, 1);
    repeat (SC - 1) step();
    check("rel.valid", valid, 1);
    check("rel.s", s, 5);
    ack = 1'b1; step(); ack = 1'b0; ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
